// File: rtl/ctrl_pkg.sv
// Shared types and constants for the control pipeline: decoded control bundle,
// per-stage register layouts and forwarding-select encodings.
package ctrl_pkg;

  localparam int RA_W    = 5;
  localparam int ALUOP_W = 2;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               branch;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Later stages keep only the control fields that are still consumed downstream.
  typedef struct packed {
    ctrl_t           ctrl;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] rd;
  } mem_wb_t;

endpackage

// File: rtl/fwd_unit.sv
// Forward-select for one EX operand: EX/MEM result beats MEM/WB result, x0 never forwards.
module fwd_unit
  import ctrl_pkg::*;
(
  input  logic [RA_W-1:0] ex_rs,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_rd,
  output logic [1:0]      sel
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers with load-use stall, branch flush
// and operand forwarding selects.
module ctrl_pipeline
  import ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ALUOP_W-1:0] id_aluop_i,
  input  logic               id_alusrc_i,
  input  logic               id_branch_i,
  input  logic               id_memread_i,
  input  logic               id_memwrite_i,
  input  logic               id_regwrite_i,
  input  logic               id_memtoreg_i,
  input  logic [RA_W-1:0]    id_rs1_i,
  input  logic [RA_W-1:0]    id_rs2_i,
  input  logic [RA_W-1:0]    id_rd_i,
  input  logic               ex_taken_i,
  output logic [ALUOP_W-1:0] ex_aluop_o,
  output logic               ex_alusrc_o,
  output logic               ex_branch_o,
  output logic               mem_memread_o,
  output logic               mem_memwrite_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o,
  output logic [RA_W-1:0]    wb_rd_o,
  output logic [1:0]         fwd_a_o,
  output logic [1:0]         fwd_b_o,
  output logic               pc_write_o,
  output logic               ifid_write_o,
  output logic               ifid_flush_o
);

  id_ex_t  id_ex_q;
  id_ex_t  id_ex_d;
  ex_mem_t ex_mem_q;
  mem_wb_t mem_wb_q;

  logic stall;
  logic flush;

  always_comb begin
    stall = id_ex_q.ctrl.memread && (id_ex_q.rd != '0) &&
            ((id_ex_q.rd == id_rs1_i) || (id_ex_q.rd == id_rs2_i));
    flush = ex_taken_i;

    // A bubble clears the whole entry so it cannot trigger forwarding either.
    id_ex_d = '0;
    if (!(stall || flush)) begin
      id_ex_d.ctrl.aluop    = id_aluop_i;
      id_ex_d.ctrl.alusrc   = id_alusrc_i;
      id_ex_d.ctrl.branch   = id_branch_i;
      id_ex_d.ctrl.memread  = id_memread_i;
      id_ex_d.ctrl.memwrite = id_memwrite_i;
      id_ex_d.ctrl.regwrite = id_regwrite_i;
      id_ex_d.ctrl.memtoreg = id_memtoreg_i;
      id_ex_d.rs1           = id_rs1_i;
      id_ex_d.rs2           = id_rs2_i;
      id_ex_d.rd            = id_rd_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all three stages shift on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q           <= id_ex_d;
      ex_mem_q.memread  <= id_ex_q.ctrl.memread;
      ex_mem_q.memwrite <= id_ex_q.ctrl.memwrite;
      ex_mem_q.regwrite <= id_ex_q.ctrl.regwrite;
      ex_mem_q.memtoreg <= id_ex_q.ctrl.memtoreg;
      ex_mem_q.rd       <= id_ex_q.rd;
      mem_wb_q.regwrite <= ex_mem_q.regwrite;
      mem_wb_q.memtoreg <= ex_mem_q.memtoreg;
      mem_wb_q.rd       <= ex_mem_q.rd;
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs        (id_ex_q.rs1),
    .mem_regwrite (ex_mem_q.regwrite),
    .mem_rd       (ex_mem_q.rd),
    .wb_regwrite  (mem_wb_q.regwrite),
    .wb_rd        (mem_wb_q.rd),
    .sel          (fwd_a_o)
  );

  fwd_unit u_fwd_b (
    .ex_rs        (id_ex_q.rs2),
    .mem_regwrite (ex_mem_q.regwrite),
    .mem_rd       (ex_mem_q.rd),
    .wb_regwrite  (mem_wb_q.regwrite),
    .wb_rd        (mem_wb_q.rd),
    .sel          (fwd_b_o)
  );

  assign ex_aluop_o     = id_ex_q.ctrl.aluop;
  assign ex_alusrc_o    = id_ex_q.ctrl.alusrc;
  assign ex_branch_o    = id_ex_q.ctrl.branch;
  assign mem_memread_o  = ex_mem_q.memread;
  assign mem_memwrite_o = ex_mem_q.memwrite;
  assign wb_regwrite_o  = mem_wb_q.regwrite;
  assign wb_memtoreg_o  = mem_wb_q.memtoreg;
  assign wb_rd_o        = mem_wb_q.rd;

  // A taken branch overrides a pending stall: the dependent instruction is squashed anyway.
  assign pc_write_o   = !stall || flush;
  assign ifid_write_o = !stall || flush;
  assign ifid_flush_o = flush;

endmodule
